// File: rtl/housekeeping_wb.sv
// Purpose: Wishbone slave for the system control window (product ID, clock/trap routing, IRQ source selects).
// Latency: ack and read data are registered one cycle after a select is sampled; control outputs update on the write edge.
// Backpressure: none; the slave never stalls. Ack is a single-cycle pulse and is forced low the cycle after it rises.
module housekeeping_wb #(
    parameter logic [31:0] SYS_BASE_ADR = 32'h2620_0000,
    parameter logic [7:0]  PRODUCT_ID   = 8'h11
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    input  logic [31:0] wb_adr_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        clk1_output_dest,
    output logic        clk2_output_dest,
    output logic        trap_output_dest,
    output logic        irq_7_inputsrc,
    output logic        irq_8_inputsrc
);

    localparam logic [7:0] OFS_ID      = 8'h00;
    localparam logic [7:0] OFS_OUTDEST = 8'h1b;
    localparam logic [7:0] OFS_IRQSRC  = 8'h1c;

    logic        select;
    logic        xfer;
    logic [7:0]  offset;
    logic [7:0]  rd_byte;

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic [2:0]  outdest_q, outdest_d;
    logic [1:0]  irqsrc_q, irqsrc_d;

    // Upper byte lanes and unused selects are intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{wb_sel_i[3:1], wb_dat_i[31:8]};

    // Decode the window, pick the read byte and compute next-state for ack, read data and registers.
    always_comb begin
        select    = wb_stb_i & wb_cyc_i & (wb_adr_i[31:8] == SYS_BASE_ADR[31:8]);
        offset    = wb_adr_i[7:0];
        // A transfer completes only on the edge that raises ack.
        xfer      = select & ~ack_q;

        rd_byte   = 8'h00;
        case (offset)
            OFS_ID:      rd_byte = PRODUCT_ID;
            OFS_OUTDEST: rd_byte = {5'b0, outdest_q};
            OFS_IRQSRC:  rd_byte = {6'b0, irqsrc_q};
            default:     rd_byte = 8'h00;
        endcase

        ack_d     = xfer;
        dat_d     = dat_q;
        outdest_d = outdest_q;
        irqsrc_d  = irqsrc_q;

        if (xfer && !wb_we_i) begin
            dat_d = {24'b0, rd_byte};
        end

        if (xfer && wb_we_i && wb_sel_i[0]) begin
            case (offset)
                OFS_OUTDEST: outdest_d = wb_dat_i[2:0];
                OFS_IRQSRC:  irqsrc_d  = wb_dat_i[1:0];
                default:     ;
            endcase
        end
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'h0;
            outdest_q <= 3'b0;
            irqsrc_q  <= 2'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            outdest_q <= outdest_d;
            irqsrc_q  <= irqsrc_d;
        end
    end

    assign wb_ack_o         = ack_q;
    assign wb_dat_o         = dat_q;
    assign clk1_output_dest = outdest_q[0];
    assign clk2_output_dest = outdest_q[1];
    assign trap_output_dest = outdest_q[2];
    assign irq_7_inputsrc   = irqsrc_q[0];
    assign irq_8_inputsrc   = irqsrc_q[1];

endmodule

// File: tb/tb_housekeeping_wb.sv
// Purpose: randomized self-checking bench for housekeeping_wb against a register-map reference model.
// Latency: expects ack and read data one cycle after select is sampled.
// Backpressure: none exercised; the slave never stalls.
module tb_housekeeping_wb;

    localparam logic [31:0] BASE = 32'h2620_0000;
    localparam logic [7:0]  PID  = 8'h11;

    logic        clk;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic        clk1, clk2, trap, irq7, irq8;

    housekeeping_wb #(.SYS_BASE_ADR(BASE), .PRODUCT_ID(PID)) dut (
        .wb_clk_i         (clk),
        .wb_rstn_i        (rst_n),
        .wb_stb_i         (stb),
        .wb_cyc_i         (cyc),
        .wb_we_i          (we),
        .wb_sel_i         (sel),
        .wb_dat_i         (dat_i),
        .wb_adr_i         (adr),
        .wb_ack_o         (ack),
        .wb_dat_o         (dat_o),
        .clk1_output_dest (clk1),
        .clk2_output_dest (clk2),
        .trap_output_dest (trap),
        .irq_7_inputsrc   (irq7),
        .irq_8_inputsrc   (irq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents and last read value.
    logic [7:0]  m_outdest;
    logic [7:0]  m_irqsrc;
    logic [31:0] m_dat;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] off);
        if (off == 8'h00)      return PID;
        else if (off == 8'h1b) return m_outdest;
        else if (off == 8'h1c) return m_irqsrc;
        else                   return 8'h00;
    endfunction

    function automatic void model_reset();
        m_outdest = 8'h0;
        m_irqsrc  = 8'h0;
        m_dat     = 32'h0;
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, "_ctl"}, {27'b0, irq8, irq7, trap, clk2, clk1},
            {27'b0, m_irqsrc[1:0], m_outdest[2:0]});
    endtask

    // One Wishbone access: select held for one sampled edge, then dropped.
    task automatic access(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, input string tag);
        logic in_win;
        in_win = (a[31:8] == BASE[31:8]);
        adr = a; we = w; sel = s; dat_i = d; stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ack"}, {31'b0, ack}, {31'b0, in_win});
        if (in_win) begin
            if (w) begin
                if (s[0] && a[7:0] == 8'h1b) m_outdest = {5'b0, d[2:0]};
                if (s[0] && a[7:0] == 8'h1c) m_irqsrc  = {6'b0, d[1:0]};
            end else begin
                m_dat = {24'b0, model_read(a[7:0])};
            end
        end
        chk({tag, "_dat"}, dat_o, m_dat);
        chk_outputs(tag);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_ackfall"}, {31'b0, ack}, 32'h0);
        chk({tag, "_dathold"}, dat_o, m_dat);
    endtask

    initial begin
        int highs;
        logic prev;
        logic [31:0] a;
        logic [31:0] snap;

        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
        sel = 4'h0; dat_i = 32'h0; adr = 32'h0;
        model_reset();
        #3;
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk_outputs("rst");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Post-reset reads.
        access(BASE | 32'h1b, 1'b0, 4'hf, 32'h0, "rd1b_rst");
        access(BASE | 32'h1c, 1'b0, 4'hf, 32'h0, "rd1c_rst");
        access(BASE | 32'h00, 1'b0, 4'hf, 32'h0, "rdid");

        // Directed writes and read-back.
        access(BASE | 32'h1b, 1'b1, 4'h1, 32'h1, "wr1b");
        access(BASE | 32'h1b, 1'b0, 4'h1, 32'h0, "rb1b");
        chk("clk1_set", {31'b0, clk1}, 32'h1);
        access(BASE | 32'h1c, 1'b1, 4'h1, 32'h1, "wr1c");
        access(BASE | 32'h1c, 1'b0, 4'h1, 32'h0, "rb1c");
        chk("irq7_set", {31'b0, irq7}, 32'h1);
        access(BASE | 32'h1c, 1'b1, 4'h1, 32'hff, "wr1c_ff");
        access(BASE | 32'h1c, 1'b0, 4'h1, 32'h0, "rb1c_ff");
        chk("rb1c_ff_val", dat_o, 32'h3);

        // sel[0]=0 write is acked but ignored.
        access(BASE | 32'h1b, 1'b1, 4'h0, 32'h6, "wr_nosel");
        access(BASE | 32'h1b, 1'b0, 4'h1, 32'h0, "rb_nosel");
        chk("nosel_val", dat_o, 32'h1);

        // Select held for 4 cycles: first ack one cycle wide, never two highs in a row.
        adr = BASE; we = 1'b0; sel = 4'h1; stb = 1'b1; cyc = 1'b1;
        highs = 0; prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("hold_ack0", {31'b0, ack}, 32'h1);
            if (i == 1) chk("hold_ack1", {31'b0, ack}, 32'h0);
            if (prev && ack) highs++;
            prev = ack;
        end
        chk("hold_nodouble", highs, 0);
        stb = 1'b0; cyc = 1'b0;
        m_dat = {24'b0, PID};
        @(posedge clk); #1;
        chk("hold_dat", dat_o, m_dat);
        @(posedge clk); #1;

        // Out-of-window access: no ack within 10 cycles, nothing changes.
        snap = dat_o;
        adr = 32'h3000_001b; we = 1'b1; sel = 4'hf; dat_i = 32'hff; stb = 1'b1; cyc = 1'b1;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ack) highs++;
        end
        chk("oow_noack", highs, 0);
        chk("oow_dat", dat_o, snap);
        chk_outputs("oow");
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 4))
                0: a = BASE | 32'h00;
                1: a = BASE | 32'h1b;
                2: a = BASE | 32'h1c;
                3: a = BASE | {24'b0, 8'($urandom)};
                default: begin
                    a = $urandom;
                    if (a[31:8] == BASE[31:8]) a[31] = ~a[31];
                end
            endcase
            access(a, 1'($urandom), 4'($urandom), $urandom, "rnd");
        end

        // Reset during a pending access: ack must not rise; registers cleared.
        access(BASE | 32'h1b, 1'b1, 4'h1, 32'h7, "pre_rst_wr");
        access(BASE | 32'h1c, 1'b1, 4'h1, 32'h3, "pre_rst_wr2");
        adr = BASE | 32'h1b; we = 1'b0; sel = 4'h1; stb = 1'b1; cyc = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_ack", {31'b0, ack}, 32'h0);
        chk("mid_rst_dat", dat_o, 32'h0);
        chk_outputs("mid_rst");
        @(posedge clk); #1;
        chk("mid_rst_noack", {31'b0, ack}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ack", {31'b0, ack}, 32'h1);
        chk("post_rst_rd1b", dat_o, 32'h0);
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
        access(BASE | 32'h1c, 1'b0, 4'h1, 32'h0, "post_rst_rd1c");
        access(BASE | 32'h00, 1'b0, 4'h1, 32'h0, "post_rst_id");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/housekeeping_wb.md
HOUSEKEEPING_WB -- requirements
Module: housekeeping_wb

Interface
REQ-001 SHALL: parameter SYS_BASE_ADR, default 32'h2620_0000, base byte address of the system control register window.
REQ-002 SHALL: parameter PRODUCT_ID, default 8'h11, value returned by the read-only ID register.
REQ-003 SHALL: one clock; reset is asynchronous and active-low.
REQ-004 SHALL: wb_clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL: wb_rstn_i  input  1  asynchronous active-low reset.
REQ-006 SHALL: wb_stb_i  input  1  Wishbone strobe.
REQ-007 SHALL: wb_cyc_i  input  1  Wishbone cycle.
REQ-008 SHALL: wb_we_i  input  1  1 = write, 0 = read.
REQ-009 SHALL: wb_sel_i  input  4  byte selects; only bit 0 is used.
REQ-010 SHALL: wb_dat_i  input  32  write data; only bits [7:0] are used.
REQ-011 SHALL: wb_adr_i  input  32  byte address.
REQ-012 SHALL: wb_ack_o  output  1  single-cycle acknowledge.
REQ-013 SHALL: wb_dat_o  output  32  registered read data.
REQ-014 SHALL: clk1_output_dest, clk2_output_dest, trap_output_dest  output  1 each  output-routing enables.
REQ-015 SHALL: irq_7_inputsrc, irq_8_inputsrc  output  1 each  IRQ input-source selects.

Function
REQ-016 SHALL: select = wb_stb_i & wb_cyc_i & (wb_adr_i[31:8] == SYS_BASE_ADR[31:8]); decode uses wb_adr_i[7:0] as the offset.
REQ-017 SHALL: register map:
- offset 0x00: read-only {PRODUCT_ID}
- offset 0x1b: R/W bit0 clk1_output_dest, bit1 clk2_output_dest, bit2 trap_output_dest, bits[7:3] read 0
- offset 0x1c: R/W bit0 irq_7_inputsrc, bit1 irq_8_inputsrc, bits[7:2] read 0
REQ-018 SHALL: wb_ack_o <= select & ~wb_ack_o each edge; ack is high exactly one cycle, one cycle after select is first sampled, and is low the following cycle even if stb remains high.
REQ-019 SHALL: addresses outside the window get no ack; wb_dat_o and registers are unchanged.
REQ-020 SHALL: on the edge that raises ack with wb_we_i=1 and wb_sel_i[0]=1, the addressed R/W register loads the applicable bits of wb_dat_i; wb_sel_i[0]=0 acks without writing.
REQ-021 SHALL: writes to read-only or unmapped offsets are acked and ignored.
REQ-022 SHALL: on the edge that raises ack with wb_we_i=0, wb_dat_o <= {24'b0, register value}; unmapped offsets return 32'h0.
REQ-023 SHALL: wb_dat_o holds its last read value, with no X bits, until the next read ack; writes do not alter it.
REQ-024 SHALL: control outputs are driven directly from register bits and change on the write edge.
REQ-025 SHALL: back-to-back transfers are supported; after stb drops, a new select is acked one cycle after it is sampled.

Reset
REQ-026 SHALL: wb_rstn_i low immediately clears wb_ack_o, wb_dat_o (32'h0) and all register bits (0x1b=0, 0x1c=0); all control outputs are 0.
REQ-027 SHALL: reset asserted mid-transfer aborts it with no register update; after release, a still-asserted select is acked one cycle after it is sampled.

Verification
REQ-028 SHALL: reset, then read 0x1b, 0x1c, 0x00 -> wb_dat_o = 32'h0, 32'h0, 32'h11 respectively; all outputs 0.
REQ-029 SHALL: write 1 to base|0x1b, then read it -> single ack per access; wb_dat_o === 32'h1 after ack falls; clk1_output_dest=1.
REQ-030 SHALL: write 1 to base|0x1c, then read it -> wb_dat_o === 32'h1; irq_7_inputsrc=1; then write 32'hFF -> read returns 32'h03.
REQ-031 SHALL: hold stb/cyc high for 4 cycles -> wb_ack_o pulses high exactly one cycle, then stays low until the next select is sampled; write with wb_sel_i=0 -> acked, register unchanged.
REQ-032 SHALL: access to address 32'h3000_001b -> no ack within 10 cycles; wb_dat_o unchanged.
REQ-033 SHALL: assert wb_rstn_i low between select sampling and ack -> ack never rises for that access; all registers read 0 after release.
